// File: rtl/mem_bus_ctl.sv
// Memory-side responder: turns processor memrq strobes into a req/done
// handshake on the external bus, with a one-deep pending slot and NXM timeout.
module mem_bus_ctl #(
  parameter int AW      = 22,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memrq,
  input  logic          memwr,
  input  logic [AW-1:0] pma,
  input  logic [31:0]   md,
  output logic [31:0]   mds,
  output logic          loadmd,
  output logic          memack,
  output logic          memstall,
  output logic          nxm,
  input  logic          nxm_clr,
  output logic          ovr,
  output logic          mcr_req,
  output logic          mcr_write,
  output logic [AW-1:0] mcr_addr,
  output logic [31:0]   mcr_wdata,
  input  logic          mcr_done,
  input  logic [31:0]   mcr_rdata
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_mds;
  logic          r_loadmd;
  logic          r_memack;
  logic          r_nxm;
  logic          r_ovr;
  logic          r_req;
  logic          r_write;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_pend_valid;
  logic          r_pend_write;
  logic [AW-1:0] r_pend_addr;
  logic [31:0]   r_pend_wdata;

  logic w_tmo;
  logic w_fin;

  assign w_tmo = (r_cnt == TMAX);
  assign w_fin = mcr_done || w_tmo;

  assign mds       = r_mds;
  assign loadmd    = r_loadmd;
  assign memack    = r_memack;
  assign memstall  = r_pend_valid;
  assign nxm       = r_nxm;
  assign ovr       = r_ovr;
  assign mcr_req   = r_req;
  assign mcr_write = r_write;
  assign mcr_addr  = r_addr;
  assign mcr_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mds        <= '0;
      r_loadmd     <= 1'b0;
      r_memack     <= 1'b0;
      r_nxm        <= 1'b0;
      r_ovr        <= 1'b0;
      r_req        <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_write <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
    end else begin
      r_loadmd <= 1'b0;
      r_memack <= 1'b0;
      // Clear first so a same-cycle set below wins.
      if (nxm_clr) begin
        r_nxm <= 1'b0;
        r_ovr <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (memrq) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= pma;
            r_wdata <= md;
            r_write <= memwr;
            r_cnt   <= '0;
          end
        end
        S_REQ: begin
          if (w_fin) begin
            r_state  <= S_DONE;
            r_req    <= 1'b0;
            r_memack <= 1'b1;
            r_cnt    <= '0;
            if (!r_write) begin
              r_loadmd <= 1'b1;
              r_mds    <= mcr_done ? mcr_rdata : 32'hFFFF_FFFF;
            end
            if (!mcr_done) r_nxm <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (memrq) begin
            if (r_pend_valid) begin
              r_ovr <= 1'b1;
            end else begin
              r_pend_valid <= 1'b1;
              r_pend_addr  <= pma;
              r_pend_wdata <= md;
              r_pend_write <= memwr;
            end
          end
        end
        S_DONE: begin
          if (r_pend_valid) begin
            r_state      <= S_REQ;
            r_req        <= 1'b1;
            r_addr       <= r_pend_addr;
            r_wdata      <= r_pend_wdata;
            r_write      <= r_pend_write;
            r_cnt        <= '0;
            r_pend_valid <= memrq;
            if (memrq) begin
              r_pend_addr  <= pma;
              r_pend_wdata <= md;
              r_pend_write <= memwr;
            end
          end else if (memrq) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= pma;
            r_wdata <= md;
            r_write <= memwr;
            r_cnt   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctl.sv
// Bench for mem_bus_ctl: directed scenarios then random traffic, all
// checked every cycle against a transaction-queue reference model.
module tb_mem_bus_ctl;

  localparam int AW = 22;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          memrq = 1'b0;
  logic          memwr = 1'b0;
  logic [AW-1:0] pma = '0;
  logic [31:0]   md = '0;
  logic [31:0]   mds;
  logic          loadmd;
  logic          memack;
  logic          memstall;
  logic          nxm;
  logic          nxm_clr = 1'b0;
  logic          ovr;
  logic          mcr_req;
  logic          mcr_write;
  logic [AW-1:0] mcr_addr;
  logic [31:0]   mcr_wdata;
  logic          mcr_done = 1'b0;
  logic [31:0]   mcr_rdata = '0;

  mem_bus_ctl #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .memrq(memrq), .memwr(memwr),
    .pma(pma), .md(md),
    .mds(mds), .loadmd(loadmd),
    .memack(memack), .memstall(memstall),
    .nxm(nxm), .nxm_clr(nxm_clr),
    .ovr(ovr),
    .mcr_req(mcr_req), .mcr_write(mcr_write),
    .mcr_addr(mcr_addr), .mcr_wdata(mcr_wdata),
    .mcr_done(mcr_done), .mcr_rdata(mcr_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic          w;
  } req_t;

  // Outstanding requests in order: head is on the bus unless m_gap.
  req_t q[$];
  bit          m_gap;
  int          m_wait;
  logic [31:0] e_mds;
  logic        e_loadmd, e_memack, e_nxm, e_ovr;
  logic [AW-1:0] e_addr;
  logic [31:0] e_wdata;
  logic        e_write;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  n;
    bit  act, fin, snx, sov;
    req_t r;
    e_loadmd = 1'b0;
    e_memack = 1'b0;
    if (reset) begin
      q.delete();
      m_gap = 0; m_wait = 0;
      e_mds = '0; e_nxm = 0; e_ovr = 0;
      e_addr = '0; e_wdata = '0; e_write = 0;
      return;
    end
    n = q.size();
    act = (n > 0) && !m_gap;
    fin = 0; snx = 0; sov = 0;
    if (act) begin
      if (mcr_done || m_wait == TO - 1) begin
        fin = 1;
        e_memack = 1'b1;
        if (!q[0].w) begin
          e_loadmd = 1'b1;
          e_mds = mcr_done ? mcr_rdata : 32'hFFFF_FFFF;
        end
        if (!mcr_done) snx = 1;
      end else begin
        m_wait++;
      end
    end
    if (memrq) begin
      if (act && n == 2) sov = 1;
      else begin
        r.a = pma; r.d = md; r.w = memwr;
        q.push_back(r);
      end
    end
    if (fin) begin
      void'(q.pop_front());
      m_gap = 1;
      m_wait = 0;
    end else begin
      m_gap = 0;
    end
    if (!act) m_wait = 0;
    if (nxm_clr) begin e_nxm = 0; e_ovr = 0; end
    if (snx) e_nxm = 1;
    if (sov) e_ovr = 1;
    if (q.size() > 0 && !m_gap) begin
      e_addr = q[0].a; e_wdata = q[0].d; e_write = q[0].w;
    end
  endtask

  task automatic check_all();
    logic er;
    logic es;
    er = (q.size() > 0) && !m_gap;
    es = (q.size() == (er ? 2 : 1));
    chk("mcr_req",   64'(mcr_req),   64'(er));
    chk("memstall",  64'(memstall),  64'(es));
    chk("memack",    64'(memack),    64'(e_memack));
    chk("loadmd",    64'(loadmd),    64'(e_loadmd));
    chk("mds",       64'(mds),       64'(e_mds));
    chk("nxm",       64'(nxm),       64'(e_nxm));
    chk("ovr",       64'(ovr),       64'(e_ovr));
    chk("mcr_addr",  64'(mcr_addr),  64'(e_addr));
    chk("mcr_wdata", 64'(mcr_wdata), 64'(e_wdata));
    chk("mcr_write", 64'(mcr_write), 64'(e_write));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic rq(input logic wr, input logic [AW-1:0] a,
                    input logic [31:0] d);
    memrq = 1'b1; memwr = wr; pma = a; md = d;
    step();
    memrq = 1'b0;
  endtask

  task automatic done(input logic [31:0] rd);
    mcr_done = 1'b1; mcr_rdata = rd;
    step();
    mcr_done = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    step();
    reset = 1'b0;
    idle(2);

    rq(1'b0, 22'h001234, 32'h0);
    idle(3);
    done(32'hDEADBEEF);
    idle(2);

    rq(1'b1, 22'h3FFFFF, 32'h0BADF00D);
    idle(4);
    done(32'h12345678);
    idle(2);

    rq(1'b0, 22'h000A0A, 32'h0);
    rq(1'b1, 22'h000B0B, 32'hB0B0B0B0);
    rq(1'b0, 22'h000C0C, 32'h0);
    idle(2);
    done(32'hAAAA5555);
    idle(3);
    done(32'h0);
    idle(2);

    rq(1'b0, 22'h155555, 32'h0);
    idle(TO + 3);
    nxm_clr = 1'b1;
    step();
    nxm_clr = 1'b0;
    idle(2);

    rq(1'b0, 22'h000111, 32'h0);
    rq(1'b0, 22'h000222, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    done(32'hCAFEF00D);
    idle(2);

    rq(1'b0, 22'h000333, 32'h0);
    idle(1);
    done(32'h01020304);
    rq(1'b1, 22'h000444, 32'h44444444);
    idle(1);
    done(32'h0);
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      int dp;
      dp = (i >= 1500 && i < 1900) ? 0 : 25;
      reset     = ($urandom_range(0, 299) == 0);
      nxm_clr   = ($urandom_range(0, 39) == 0);
      memrq     = ($urandom_range(0, 99) < 30);
      memwr     = $urandom_range(0, 1) == 1;
      pma       = AW'($urandom);
      md        = $urandom;
      mcr_done  = ($urandom_range(0, 99) < dp);
      mcr_rdata = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
